// File: rtl/mem_stage_dm.sv
// MEM-stage data memory and load/store unit.
// Word-organised RAM with byte/half/word access and a committed-store counter.
module mem_stage_dm #(
   parameter int ADDR_BITS = 12,
   parameter bit LOG_EN    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr_M,
   input  logic [31:0] PC_M,
   input  logic [31:0] ALUOut_M,
   input  logic [31:0] WD_M,
   output logic [31:0] RD_M,
   output logic        misalign_M,
   output logic [31:0] store_cnt
);
   localparam int DEPTH = 1 << ADDR_BITS;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;

   logic [31:0]          r_mem [DEPTH];
   logic [31:0]          r_cnt;

   logic                 w_load;
   logic                 w_store;
   logic                 w_word_sz;
   logic                 w_half_sz;
   logic                 w_byte_sz;
   logic                 w_sext;
   logic [1:0]           w_off;
   logic [ADDR_BITS-1:0] w_idx;
   logic                 w_oor;
   logic                 w_mis;
   logic                 w_bad;
   logic                 w_commit;
   logic [31:0]          w_word;
   logic [3:0]           w_be;
   logic [31:0]          w_wdata;
   logic [31:0]          w_merged;
   logic [15:0]          w_half;
   logic [7:0]           w_byte;
   logic [31:0]          w_rd;

   always_comb begin
      w_load    = 1'b0;
      w_store   = 1'b0;
      w_word_sz = 1'b0;
      w_half_sz = 1'b0;
      w_byte_sz = 1'b0;
      w_sext    = 1'b0;
      unique case (Instr_M[31:26])
         OP_LW:  begin w_load  = 1'b1; w_word_sz = 1'b1; end
         OP_LH:  begin w_load  = 1'b1; w_half_sz = 1'b1; w_sext = 1'b1; end
         OP_LHU: begin w_load  = 1'b1; w_half_sz = 1'b1; end
         OP_LB:  begin w_load  = 1'b1; w_byte_sz = 1'b1; w_sext = 1'b1; end
         OP_LBU: begin w_load  = 1'b1; w_byte_sz = 1'b1; end
         OP_SW:  begin w_store = 1'b1; w_word_sz = 1'b1; end
         OP_SH:  begin w_store = 1'b1; w_half_sz = 1'b1; end
         OP_SB:  begin w_store = 1'b1; w_byte_sz = 1'b1; end
         default: ;
      endcase
   end

   assign w_off    = ALUOut_M[1:0];
   assign w_idx    = ALUOut_M[ADDR_BITS+1:2];
   assign w_oor    = |ALUOut_M[31:ADDR_BITS+2];
   assign w_mis    = (w_word_sz && w_off != 2'b00) || (w_half_sz && w_off[0]);
   assign w_bad    = (w_load || w_store) && (w_mis || w_oor);
   assign w_commit = w_store && !w_bad;
   assign w_word   = r_mem[w_idx];

   always_comb begin
      w_be    = 4'b0000;
      w_wdata = WD_M;
      if (w_half_sz) w_wdata = {2{WD_M[15:0]}};
      if (w_byte_sz) w_wdata = {4{WD_M[7:0]}};
      if (w_commit) begin
         unique case (1'b1)
            w_word_sz: w_be = 4'b1111;
            w_half_sz: w_be = w_off[1] ? 4'b1100 : 4'b0011;
            w_byte_sz: w_be = 4'b0001 << w_off;
            default:   w_be = 4'b0000;
         endcase
      end
      for (int b = 0; b < 4; b++)
         w_merged[8*b +: 8] = w_be[b] ? w_wdata[8*b +: 8] : w_word[8*b +: 8];
   end

   always_comb begin
      w_rd   = '0;
      w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
      w_byte = w_word[8*w_off +: 8];
      if (w_load && !w_bad) begin
         unique case (1'b1)
            w_word_sz: w_rd = w_word;
            w_half_sz: w_rd = {{16{w_sext & w_half[15]}}, w_half};
            w_byte_sz: w_rd = {{24{w_sext & w_byte[7]}}, w_byte};
            default:   w_rd = '0;
         endcase
      end
   end

   // Reset clears the whole array so loads read 0 without extra gating.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_cnt <= '0;
      end else if (w_commit) begin
         r_mem[w_idx] <= w_merged;
         r_cnt        <= r_cnt + 32'd1;
         if (LOG_EN)
            $display("%d@%h: *%h <= %h", $time, PC_M,
                     {ALUOut_M[31:2], 2'b00}, w_merged);
      end
   end

   assign RD_M       = w_rd;
   assign misalign_M = w_bad;
   assign store_cnt  = r_cnt;

endmodule

// File: tb/tb_mem_stage_dm.sv
// Directed bench for mem_stage_dm.
// Each task drives one scenario and checks results inline.
module tb_mem_stage_dm;
   logic        clk;
   logic        reset;
   logic [31:0] Instr_M;
   logic [31:0] PC_M;
   logic [31:0] ALUOut_M;
   logic [31:0] WD_M;
   logic [31:0] RD_M;
   logic        misalign_M;
   logic [31:0] store_cnt;

   int errs;
   int checks;

   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] LH  = 6'b100001;
   localparam logic [5:0] LHU = 6'b100101;
   localparam logic [5:0] LB  = 6'b100000;
   localparam logic [5:0] LBU = 6'b100100;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] SH  = 6'b101001;
   localparam logic [5:0] SB  = 6'b101000;
   localparam logic [5:0] NOP = 6'b000000;

   mem_stage_dm #(.ADDR_BITS(12), .LOG_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .Instr_M(Instr_M), .PC_M(PC_M),
      .ALUOut_M(ALUOut_M), .WD_M(WD_M), .RD_M(RD_M),
      .misalign_M(misalign_M), .store_cnt(store_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] d);
      Instr_M  = {op, 26'h0};
      ALUOut_M = a;
      WD_M     = d;
      PC_M     = PC_M + 32'd4;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      PC_M  = 32'h0000_3000;
      drive(NOP, 32'h0, 32'h0);
      checks++;
      if (store_cnt !== 32'd0) begin
         errs++; $display("FAIL reset_cnt got=%h exp=%h", store_cnt, 32'd0);
      end
      drive(LW, 32'h10, 32'h0);
      checks++;
      if (RD_M !== 32'h0) begin
         errs++; $display("FAIL reset_rd got=%h exp=%h", RD_M, 32'h0);
      end
      step();
      reset = 1'b1;
   endtask

   task automatic test_word();
      drive(SW, 32'h10, 32'h1234_5678);
      checks++;
      if (misalign_M !== 1'b0 || RD_M !== 32'h0) begin
         errs++; $display("FAIL sw_comb got=%b/%h exp=0/0", misalign_M, RD_M);
      end
      step();
      drive(LW, 32'h10, 32'h0);
      checks++;
      if (RD_M !== 32'h1234_5678) begin
         errs++; $display("FAIL lw_10 got=%h exp=%h", RD_M, 32'h1234_5678);
      end
      checks++;
      if (store_cnt !== 32'd1) begin
         errs++; $display("FAIL cnt_1 got=%0d exp=1", store_cnt);
      end
   endtask

   task automatic test_byte();
      drive(SB, 32'h11, 32'h1234_56AB);
      step();
      drive(LW, 32'h10, 32'h0);
      checks++;
      if (RD_M !== 32'h1234_AB78) begin
         errs++; $display("FAIL sb_word got=%h exp=%h", RD_M, 32'h1234_AB78);
      end
      drive(LB, 32'h11, 32'h0);
      checks++;
      if (RD_M !== 32'hFFFF_FFAB) begin
         errs++; $display("FAIL lb_11 got=%h exp=%h", RD_M, 32'hFFFF_FFAB);
      end
      drive(LBU, 32'h11, 32'h0);
      checks++;
      if (RD_M !== 32'h0000_00AB) begin
         errs++; $display("FAIL lbu_11 got=%h exp=%h", RD_M, 32'h0000_00AB);
      end
      drive(LB, 32'h10, 32'h0);
      checks++;
      if (RD_M !== 32'h0000_0078) begin
         errs++; $display("FAIL lb_10 got=%h exp=%h", RD_M, 32'h0000_0078);
      end
   endtask

   task automatic test_half();
      drive(SH, 32'h22, 32'hCDEF_8001);
      step();
      drive(LH, 32'h22, 32'h0);
      checks++;
      if (RD_M !== 32'hFFFF_8001) begin
         errs++; $display("FAIL lh_22 got=%h exp=%h", RD_M, 32'hFFFF_8001);
      end
      drive(LHU, 32'h22, 32'h0);
      checks++;
      if (RD_M !== 32'h0000_8001) begin
         errs++; $display("FAIL lhu_22 got=%h exp=%h", RD_M, 32'h0000_8001);
      end
      drive(LH, 32'h20, 32'h0);
      checks++;
      if (RD_M !== 32'h0) begin
         errs++; $display("FAIL lh_20 got=%h exp=%h", RD_M, 32'h0);
      end
      drive(LW, 32'h20, 32'h0);
      checks++;
      if (RD_M !== 32'h8001_0000) begin
         errs++; $display("FAIL sh_word got=%h exp=%h", RD_M, 32'h8001_0000);
      end
      checks++;
      if (store_cnt !== 32'd3) begin
         errs++; $display("FAIL cnt_3 got=%0d exp=3", store_cnt);
      end
   endtask

   task automatic test_misalign();
      drive(SW, 32'h13, 32'hFFFF_FFFF);
      checks++;
      if (misalign_M !== 1'b1) begin
         errs++; $display("FAIL sw_13_mis got=%b exp=1", misalign_M);
      end
      step();
      drive(LW, 32'h10, 32'h0);
      checks++;
      if (RD_M !== 32'h1234_AB78 || store_cnt !== 32'd3) begin
         errs++; $display("FAIL sw_13_nowr got=%h/%0d exp=1234ab78/3",
                          RD_M, store_cnt);
      end
      drive(LH, 32'h21, 32'h0);
      checks++;
      if (misalign_M !== 1'b1 || RD_M !== 32'h0) begin
         errs++; $display("FAIL lh_21 got=%b/%h exp=1/0", misalign_M, RD_M);
      end
      drive(LW, 32'h12, 32'h0);
      checks++;
      if (misalign_M !== 1'b1 || RD_M !== 32'h0) begin
         errs++; $display("FAIL lw_12 got=%b/%h exp=1/0", misalign_M, RD_M);
      end
      drive(LB, 32'h13, 32'h0);
      checks++;
      if (misalign_M !== 1'b0 || RD_M !== 32'h0000_0012) begin
         errs++; $display("FAIL lb_13 got=%b/%h exp=0/12", misalign_M, RD_M);
      end
   endtask

   task automatic test_range();
      drive(SW, 32'h4000, 32'hDEAD_BEEF);
      checks++;
      if (misalign_M !== 1'b1) begin
         errs++; $display("FAIL oor_mis got=%b exp=1", misalign_M);
      end
      step();
      drive(LW, 32'h0, 32'h0);
      checks++;
      if (RD_M !== 32'h0 || store_cnt !== 32'd3) begin
         errs++; $display("FAIL oor_nowr got=%h/%0d exp=0/3", RD_M, store_cnt);
      end
      drive(LW, 32'h3FFC, 32'h0);
      checks++;
      if (misalign_M !== 1'b0 || RD_M !== 32'h0) begin
         errs++; $display("FAIL top_word got=%b/%h exp=0/0", misalign_M, RD_M);
      end
      drive(NOP, 32'h13, 32'h0);
      checks++;
      if (misalign_M !== 1'b0 || RD_M !== 32'h0) begin
         errs++; $display("FAIL nop got=%b/%h exp=0/0", misalign_M, RD_M);
      end
   endtask

   task automatic test_back_to_back();
      drive(SW, 32'h10, 32'hAAAA_0001);
      step();
      drive(SW, 32'h14, 32'hBBBB_0002);
      step();
      checks++;
      if (store_cnt !== 32'd5) begin
         errs++; $display("FAIL b2b_cnt got=%0d exp=5", store_cnt);
      end
      drive(LW, 32'h10, 32'h0);
      checks++;
      if (RD_M !== 32'hAAAA_0001) begin
         errs++; $display("FAIL b2b_10 got=%h exp=%h", RD_M, 32'hAAAA_0001);
      end
      drive(LW, 32'h14, 32'h0);
      checks++;
      if (RD_M !== 32'hBBBB_0002) begin
         errs++; $display("FAIL b2b_14 got=%h exp=%h", RD_M, 32'hBBBB_0002);
      end
   endtask

   task automatic test_reset_mid();
      drive(SW, 32'h18, 32'h0000_0055);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (store_cnt !== 32'd0) begin
         errs++; $display("FAIL rmid_cnt got=%0d exp=0", store_cnt);
      end
      drive(LW, 32'h10, 32'h0);
      checks++;
      if (RD_M !== 32'h0) begin
         errs++; $display("FAIL rmid_rd got=%h exp=0", RD_M);
      end
      drive(SW, 32'h18, 32'h0000_0055);
      step();
      drive(LW, 32'h18, 32'h0);
      checks++;
      if (RD_M !== 32'h0 || store_cnt !== 32'd0) begin
         errs++; $display("FAIL rlow_edge got=%h/%0d exp=0/0", RD_M, store_cnt);
      end
      reset = 1'b1;
      drive(SB, 32'h1B, 32'h0000_00C3);
      step();
      drive(LW, 32'h18, 32'h0);
      checks++;
      if (RD_M !== 32'hC300_0000 || store_cnt !== 32'd1) begin
         errs++; $display("FAIL post_rst got=%h/%0d exp=c3000000/1",
                          RD_M, store_cnt);
      end
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misalign();
      test_range();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
